// File: rtl/hazard_controller.sv
// hazard_controller: per-stage stall/flush generation for an N-stage pipeline.
// Combines trap detection with a drain state machine, multi-cycle load-use
// bubble insertion and a watchdog on the external stall request.
// Stage 0 is the fetch/decode register; stage STAGES-1 is memory/writeback.
module hazard_controller #(
    parameter int STAGES           = 4,
    parameter int SRC_REGS         = 2,
    parameter int REG_W            = 5,
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int TRAP_DRAIN       = 2,
    parameter int STALL_TIMEOUT    = 255
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [STAGES-1:0]           stage_valid,
    input  logic [STAGES-1:0]           stage_illegal,
    input  logic                        branch_valid,
    input  logic                        stall_request,
    input  logic [SRC_REGS*REG_W-1:0]   src_reg,
    input  logic [REG_W-1:0]            load_dest_reg,
    input  logic                        load_is_mem,
    output logic [STAGES-1:0]           stall,
    output logic [STAGES-1:0]           flush,
    output logic                        trap_redirect,
    output logic [$clog2(STAGES)-1:0]   trap_stage,
    output logic                        trap_timeout,
    output logic                        trap_busy
);

    localparam int STAGE_W = $clog2(STAGES);
    localparam int BUB_W   = $clog2(LOAD_USE_BUBBLES + 1);
    localparam int DRAIN_W = $clog2(TRAP_DRAIN + 1);
    localparam int WD_W    = $clog2(STALL_TIMEOUT + 1);

    localparam logic [BUB_W-1:0]   BUB_LOAD   = BUB_W'(LOAD_USE_BUBBLES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(TRAP_DRAIN - 1);
    localparam logic [WD_W-1:0]    WD_MAX     = WD_W'(STALL_TIMEOUT);
    localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(STAGES - 1);

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t               state;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic [BUB_W-1:0]     bubble_cnt;
    logic [WD_W-1:0]      wd_cnt;

    logic [STAGES-1:0]    illegal_vec;
    logic                 illegal_any;
    logic [STAGE_W-1:0]   illegal_k;
    logic                 wd_expired;
    logic                 trap_take;
    logic [STAGE_W-1:0]   trap_k;
    logic                 src_match;
    logic                 load_use_hit;
    logic                 bubble_active;

    assign illegal_vec   = stage_valid & stage_illegal;
    assign illegal_any   = |illegal_vec;
    assign wd_expired    = stall_request && (wd_cnt == WD_MAX);
    assign trap_take     = (state == IDLE) && (illegal_any || wd_expired);
    assign trap_k        = wd_expired ? LAST_STAGE : illegal_k;
    assign load_use_hit  = stage_valid[1] & stage_valid[2] & load_is_mem & src_match;
    assign bubble_active = load_use_hit || (bubble_cnt != '0);
    assign trap_busy     = (state == DRAIN);

    // Find the oldest (highest-index) valid stage carrying an illegal flag.
    always_comb begin
        illegal_k = '0;
        for (int s = 0; s < STAGES; s++) begin
            if (illegal_vec[s]) begin
                illegal_k = STAGE_W'(s);
            end
        end
    end

    // Compare every nonzero stage-1 source operand against the load destination.
    always_comb begin
        src_match = 1'b0;
        for (int i = 0; i < SRC_REGS; i++) begin
            if ((src_reg[i*REG_W +: REG_W] != '0) &&
                (src_reg[i*REG_W +: REG_W] == load_dest_reg)) begin
                src_match = 1'b1;
            end
        end
    end

    // Prioritised stall/flush: trap or drain, then branch, then stall and bubbles.
    always_comb begin
        stall         = '0;
        flush         = '0;
        trap_redirect = 1'b0;
        if (!reset) begin
            stall         = '0;
        end else if (state == DRAIN) begin
            flush         = '1;
        end else if (trap_take) begin
            trap_redirect = 1'b1;
            for (int s = 0; s < STAGES; s++) begin
                flush[s] = (s <= int'(trap_k) + 1);
            end
        end else if (branch_valid) begin
            flush[1:0]    = 2'b11;
        end else if (stall_request) begin
            // A pending bubble is frozen rather than inserted while memory is busy.
            stall         = '1;
        end else if (bubble_active) begin
            stall[1:0]    = 2'b11;
            flush[2]      = 1'b1;
        end
    end

    // Trap state machine together with the drain, bubble and watchdog counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            drain_cnt    <= '0;
            bubble_cnt   <= '0;
            wd_cnt       <= '0;
            trap_stage   <= '0;
            trap_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (trap_take) begin
                        state        <= DRAIN;
                        drain_cnt    <= DRAIN_LOAD;
                        trap_stage   <= trap_k;
                        trap_timeout <= wd_expired && !illegal_any;
                        bubble_cnt   <= '0;
                        wd_cnt       <= '0;
                    end else begin
                        if (stall_request) begin
                            if (wd_cnt != WD_MAX) begin
                                wd_cnt <= wd_cnt + WD_W'(1);
                            end
                        end else begin
                            wd_cnt <= '0;
                        end
                        if (branch_valid) begin
                            bubble_cnt <= '0;
                        end else if (stall_request) begin
                            bubble_cnt <= bubble_cnt;
                        end else if (bubble_cnt != '0) begin
                            bubble_cnt <= bubble_cnt - BUB_W'(1);
                        end else if (load_use_hit) begin
                            bubble_cnt <= BUB_LOAD;
                        end
                    end
                end
                DRAIN: begin
                    bubble_cnt <= '0;
                    wd_cnt     <= '0;
                    if (drain_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed scenarios followed by randomized traffic,
// all cycles checked against a behavioural model of the hazard rules.
module tb_hazard_controller;

    localparam int STAGES           = 4;
    localparam int SRC_REGS         = 2;
    localparam int REG_W            = 5;
    localparam int LOAD_USE_BUBBLES = 3;
    localparam int TRAP_DRAIN       = 2;
    localparam int STALL_TIMEOUT    = 4;
    localparam logic [STAGES-1:0] ALL_STAGES = '1;

    logic                       clock = 1'b0;
    logic                       reset;
    logic [STAGES-1:0]          stage_valid;
    logic [STAGES-1:0]          stage_illegal;
    logic                       branch_valid;
    logic                       stall_request;
    logic [SRC_REGS*REG_W-1:0]  src_reg;
    logic [REG_W-1:0]           load_dest_reg;
    logic                       load_is_mem;
    logic [STAGES-1:0]          stall;
    logic [STAGES-1:0]          flush;
    logic                       trap_redirect;
    logic [$clog2(STAGES)-1:0]  trap_stage;
    logic                       trap_timeout;
    logic                       trap_busy;

    int assert_count = 0;
    int fail_count   = 0;

    // Model state: remaining drain cycles, bubbles still owed, consecutive stall cycles.
    int m_drain;
    int m_owed;
    int m_wd;
    int m_trap_stage;
    bit m_trap_timeout;

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    hazard_controller #(
        .STAGES           (STAGES),
        .SRC_REGS         (SRC_REGS),
        .REG_W            (REG_W),
        .LOAD_USE_BUBBLES (LOAD_USE_BUBBLES),
        .TRAP_DRAIN       (TRAP_DRAIN),
        .STALL_TIMEOUT    (STALL_TIMEOUT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .stage_valid   (stage_valid),
        .stage_illegal (stage_illegal),
        .branch_valid  (branch_valid),
        .stall_request (stall_request),
        .src_reg       (src_reg),
        .load_dest_reg (load_dest_reg),
        .load_is_mem   (load_is_mem),
        .stall         (stall),
        .flush         (flush),
        .trap_redirect (trap_redirect),
        .trap_stage    (trap_stage),
        .trap_timeout  (trap_timeout),
        .trap_busy     (trap_busy)
    );

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int highest_illegal();
        int k;
        k = -1;
        for (int s = 0; s < STAGES; s++) begin
            if (stage_valid[s] && stage_illegal[s]) k = s;
        end
        return k;
    endfunction

    function automatic bit load_use_seen();
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < SRC_REGS; i++) begin
            if (src_reg[i*REG_W +: REG_W] != 0 && src_reg[i*REG_W +: REG_W] == load_dest_reg)
                hit = 1'b1;
        end
        return hit && stage_valid[1] && stage_valid[2] && load_is_mem;
    endfunction

    task automatic model_outputs(output logic [STAGES-1:0] exp_stall,
                                 output logic [STAGES-1:0] exp_flush,
                                 output logic exp_redirect);
        int k;
        int top;
        bit expiry;
        exp_stall    = '0;
        exp_flush    = '0;
        exp_redirect = 1'b0;
        if (m_drain > 0) begin
            exp_flush = ALL_STAGES;
        end else begin
            k      = highest_illegal();
            expiry = stall_request && (m_wd >= STALL_TIMEOUT);
            if (expiry) k = STAGES - 1;
            if (k >= 0) begin
                top          = (k + 1 > STAGES - 1) ? STAGES - 1 : k + 1;
                exp_flush    = STAGES'((1 << (top + 1)) - 1);
                exp_redirect = 1'b1;
            end else if (branch_valid) begin
                exp_flush = STAGES'(3);
            end else if (stall_request) begin
                exp_stall = ALL_STAGES;
            end else if (m_owed > 0 || load_use_seen()) begin
                exp_stall = STAGES'(3);
                exp_flush = STAGES'(4);
            end
        end
    endtask

    task automatic model_advance();
        int k;
        bit expiry;
        if (m_drain > 0) begin
            m_drain--;
            m_wd   = 0;
            m_owed = 0;
        end else begin
            k      = highest_illegal();
            expiry = stall_request && (m_wd >= STALL_TIMEOUT);
            if (k >= 0 || expiry) begin
                m_trap_stage   = expiry ? STAGES - 1 : k;
                m_trap_timeout = expiry && (k < 0);
                m_drain        = TRAP_DRAIN;
                m_wd           = 0;
                m_owed         = 0;
            end else begin
                m_wd = stall_request ? ((m_wd + 1 > STALL_TIMEOUT) ? STALL_TIMEOUT : m_wd + 1) : 0;
                if (branch_valid) begin
                    m_owed = 0;
                end else if (!stall_request && (m_owed > 0 || load_use_seen())) begin
                    if (m_owed == 0) m_owed = LOAD_USE_BUBBLES;
                    m_owed--;
                end
            end
        end
    endtask

    task automatic model_reset();
        m_drain        = 0;
        m_owed         = 0;
        m_wd           = 0;
        m_trap_stage   = 0;
        m_trap_timeout = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [STAGES-1:0] valid, input logic [STAGES-1:0] illegal,
                                  input logic branch, input logic stall_req,
                                  input logic [SRC_REGS*REG_W-1:0] src,
                                  input logic [REG_W-1:0] dest, input logic mem);
        stage_valid   = valid;
        stage_illegal = illegal;
        branch_valid  = branch;
        stall_request = stall_req;
        src_reg       = src;
        load_dest_reg = dest;
        load_is_mem   = mem;
    endtask

    // Constant checks taken mid-cycle, after the combinational outputs settle.
    task automatic check_output(input string tag, input logic [STAGES-1:0] exp_stall,
                                input logic [STAGES-1:0] exp_flush, input logic exp_redirect,
                                input logic exp_busy);
        #2;
        check_value({tag, "_stall"}, stall, exp_stall);
        check_value({tag, "_flush"}, flush, exp_flush);
        check_value({tag, "_redirect"}, trap_redirect, exp_redirect);
        check_value({tag, "_busy"}, trap_busy, exp_busy);
    endtask

    // One clock cycle: compare against the model at the falling edge, advance at the rising edge.
    task automatic run_cycle();
        logic [STAGES-1:0] es;
        logic [STAGES-1:0] ef;
        logic              et;
        @(negedge clock);
        model_outputs(es, ef, et);
        check_value("model_stall", stall, es);
        check_value("model_flush", flush, ef);
        check_value("model_redirect", trap_redirect, et);
        check_value("model_trap_stage", trap_stage, m_trap_stage);
        check_value("model_trap_timeout", trap_timeout, m_trap_timeout);
        check_value("model_busy", trap_busy, m_drain > 0);
        @(posedge clock);
        if (reset) model_advance();
        else model_reset();
        #1;
    endtask

    initial begin
        logic sr;
        reset = 1'b0;
        model_reset();
        apply_stimulus('0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        #3;
        check_value("reset_stall", stall, 0);
        check_value("reset_flush", flush, 0);
        check_value("reset_redirect", trap_redirect, 0);
        check_value("reset_trap_stage", trap_stage, 0);
        check_value("reset_trap_timeout", trap_timeout, 0);
        check_value("reset_busy", trap_busy, 0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Illegal instruction in stage 1: partial flush, then two drain cycles.
        apply_stimulus(4'b0010, 4'b0010, 1'b0, 1'b0, '0, '0, 1'b0);
        check_output("ill1_trap", 4'b0000, 4'b0111, 1'b1, 1'b0);
        run_cycle();
        check_value("ill1_trap_stage", trap_stage, 1);
        apply_stimulus('0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        check_output("ill1_drain_a", 4'b0000, 4'b1111, 1'b0, 1'b1);
        run_cycle();
        check_output("ill1_drain_b", 4'b0000, 4'b1111, 1'b0, 1'b1);
        run_cycle();
        check_output("ill1_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);
        run_cycle();

        // Illegal in stages 1 and 3: oldest wins, inputs held through drain give one pulse.
        apply_stimulus(4'b1010, 4'b1010, 1'b0, 1'b0, '0, '0, 1'b0);
        check_output("ill13_trap", 4'b0000, 4'b1111, 1'b1, 1'b0);
        run_cycle();
        check_value("ill13_trap_stage", trap_stage, 3);
        check_output("ill13_drain_a", 4'b0000, 4'b1111, 1'b0, 1'b1);
        run_cycle();
        check_output("ill13_drain_b", 4'b0000, 4'b1111, 1'b0, 1'b1);
        run_cycle();
        apply_stimulus('0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        check_output("ill13_idle", 4'b0000, 4'b0000, 1'b0, 1'b0);
        run_cycle();

        // Load-use: three bubbles, continuing after the comparator stops matching.
        apply_stimulus(4'b0110, '0, 1'b0, 1'b0, 10'd5, 5'd5, 1'b1);
        check_output("lu_b1", 4'b0011, 4'b0100, 1'b0, 1'b0);
        run_cycle();
        apply_stimulus(4'b0110, '0, 1'b0, 1'b0, 10'd0, 5'd5, 1'b1);
        check_output("lu_b2", 4'b0011, 4'b0100, 1'b0, 1'b0);
        run_cycle();
        check_output("lu_b3", 4'b0011, 4'b0100, 1'b0, 1'b0);
        run_cycle();
        check_output("lu_done", 4'b0000, 4'b0000, 1'b0, 1'b0);
        run_cycle();
        apply_stimulus(4'b0110, '0, 1'b0, 1'b0, 10'd0, 5'd0, 1'b1);
        check_output("lu_zero_reg", 4'b0000, 4'b0000, 1'b0, 1'b0);
        run_cycle();

        // Load-use with a two-cycle external stall in the middle of the bubble run.
        apply_stimulus(4'b0110, '0, 1'b0, 1'b0, 10'd5, 5'd5, 1'b1);
        check_output("lus_b1", 4'b0011, 4'b0100, 1'b0, 1'b0);
        run_cycle();
        apply_stimulus(4'b0110, '0, 1'b0, 1'b1, 10'd0, 5'd5, 1'b1);
        check_output("lus_freeze_a", 4'b1111, 4'b0000, 1'b0, 1'b0);
        run_cycle();
        check_output("lus_freeze_b", 4'b1111, 4'b0000, 1'b0, 1'b0);
        run_cycle();
        apply_stimulus(4'b0110, '0, 1'b0, 1'b0, 10'd0, 5'd5, 1'b1);
        check_output("lus_b2", 4'b0011, 4'b0100, 1'b0, 1'b0);
        run_cycle();
        check_output("lus_b3", 4'b0011, 4'b0100, 1'b0, 1'b0);
        run_cycle();
        check_output("lus_done", 4'b0000, 4'b0000, 1'b0, 1'b0);
        run_cycle();

        // Watchdog: four stalled cycles, trap on the fifth.
        apply_stimulus('0, '0, 1'b0, 1'b1, '0, '0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_output("wd_stall", 4'b1111, 4'b0000, 1'b0, 1'b0);
            run_cycle();
        end
        check_output("wd_trap", 4'b0000, 4'b1111, 1'b1, 1'b0);
        run_cycle();
        apply_stimulus('0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        check_value("wd_trap_timeout", trap_timeout, 1);
        check_value("wd_trap_stage", trap_stage, 3);
        check_output("wd_drain_a", 4'b0000, 4'b1111, 1'b0, 1'b1);
        run_cycle();
        check_output("wd_drain_b", 4'b0000, 4'b1111, 1'b0, 1'b1);
        run_cycle();

        // Releasing the stall early restarts the watchdog count.
        apply_stimulus('0, '0, 1'b0, 1'b1, '0, '0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check_output("wd_early", 4'b1111, 4'b0000, 1'b0, 1'b0);
            run_cycle();
        end
        apply_stimulus('0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        check_output("wd_release", 4'b0000, 4'b0000, 1'b0, 1'b0);
        run_cycle();
        apply_stimulus('0, '0, 1'b0, 1'b1, '0, '0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_output("wd_restart", 4'b1111, 4'b0000, 1'b0, 1'b0);
            run_cycle();
        end
        apply_stimulus('0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        run_cycle();

        // Branch together with a load-use hit: branch wins, no bubble follows.
        apply_stimulus(4'b0110, '0, 1'b1, 1'b0, 10'd5, 5'd5, 1'b1);
        check_output("br_lu", 4'b0000, 4'b0011, 1'b0, 1'b0);
        run_cycle();
        apply_stimulus(4'b0110, '0, 1'b0, 1'b0, 10'd0, 5'd5, 1'b1);
        check_output("br_no_bubble", 4'b0000, 4'b0000, 1'b0, 1'b0);
        run_cycle();

        // Reset pulse while draining clears everything at once.
        apply_stimulus(4'b0010, 4'b0010, 1'b0, 1'b0, '0, '0, 1'b0);
        run_cycle();
        reset = 1'b0;
        model_reset();
        #1;
        check_value("rst_drain_stall", stall, 0);
        check_value("rst_drain_flush", flush, 0);
        check_value("rst_drain_redirect", trap_redirect, 0);
        check_value("rst_drain_busy", trap_busy, 0);
        check_value("rst_drain_trap_stage", trap_stage, 0);
        @(posedge clock);
        #1;
        apply_stimulus('0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
        reset = 1'b1;

        // Randomized traffic against the model.
        sr = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (sr) sr = ($urandom_range(0, 9) < 8);
            else    sr = ($urandom_range(0, 3) == 0);
            apply_stimulus(4'($urandom),
                           ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000,
                           ($urandom_range(0, 7) == 0),
                           sr,
                           {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))},
                           5'($urandom_range(0, 3)),
                           1'($urandom));
            run_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Parametrised successor to the pipeline hazard/trap unit. Generates per-stage stall and flush controls for an N-stage register pipeline.
- Adds sequential behaviour: a trap drain state machine, multi-cycle load-use bubble insertion and an external-stall watchdog.
- Sits in CPU/Control between the pipeline registers and the PC/trap redirect logic. Stage index 0 = fetch/decode register; index STAGES-1 = memory/writeback register.

Parameters:
- STAGES, 4, number of pipeline registers controlled (>=3)
- SRC_REGS, 2, number of source register operands checked in stage 1
- REG_W, 5, register address width
- LOAD_USE_BUBBLES, 1, bubble cycles inserted per load-use hazard (>=1)
- TRAP_DRAIN, 2, cycles all stages stay flushed after a trap (>=1)
- STALL_TIMEOUT, 255, consecutive stall_request cycles before a watchdog trap

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous, active-low reset
- stage_valid  in  STAGES  valid bit of each pipeline register
- stage_illegal  in  STAGES  illegal/misaligned flag of each pipeline register
- branch_valid  in  1  PC redirect request
- stall_request  in  1  external stall (e.g. memory busy)
- src_reg  in  SRC_REGS*REG_W  stage-1 source registers, operand i at [i*REG_W +: REG_W]
- load_dest_reg  in  REG_W  stage-2 destination register
- load_is_mem  in  1  stage-2 writeback type is memory load
- stall  out  STAGES  per-stage stall
- flush  out  STAGES  per-stage flush
- trap_redirect  out  1  one-cycle pulse on trap entry
- trap_stage  out  $clog2(STAGES)  index of the stage that caused the last trap
- trap_timeout  out  1  last trap caused by watchdog
- trap_busy  out  1  FSM in DRAIN

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE; bubble and watchdog counters=0; trap_stage=0; trap_timeout=0. Combinational outputs stall, flush and trap_redirect are 0 while reset is low.
- Trap detect (IDLE only):
  - k = highest index with stage_valid[k] & stage_illegal[k].
  - Watchdog expiry also forms a trap, treated as k=STAGES-1.
  - In the same cycle: flush[min(k+1,STAGES-1):0]=1; trap_redirect=1; trap_stage<=k; trap_timeout<=(watchdog expiry and no illegal stage).
  - Next state DRAIN with drain counter=TRAP_DRAIN-1.
- DRAIN: flush all stages, stall=0, trap_busy=1, and ignore new trap inputs. Decrement the counter; return to IDLE the cycle after it reaches 0. Bubble and watchdog counters clear on entry.
- Branch (IDLE, no trap): flush[1:0]=1. Clears the bubble counter; the load-use consumer is killed.
- Load-use detect: stage_valid[1] & stage_valid[2] & load_is_mem & any src_reg[i]!=0 & src_reg[i]==load_dest_reg.
  - First cycle: stall[1:0]=1, flush[2]=1; bubble counter<=LOAD_USE_BUBBLES-1.
  - While counter!=0: same stall/flush pattern and decrement, even though the comparator no longer matches.
  - A new detection while the counter is nonzero does not reload the counter.
- External stall: stall_request sets stall on all stages. Bubble counter holds (no decrement). Watchdog increments, saturating at STALL_TIMEOUT, and resets to 0 when stall_request=0. Expiry = counter==STALL_TIMEOUT with stall_request=1.
- Priority per cycle: trap/DRAIN > branch > load-use/external stall (OR-ed). Final per-stage rule: if flush[s]=1 then stall[s]=0, except the load-use bubble flush[2] under stall_request, where stall[2]=1 and flush[2]=0 (freeze, no bubble).
- Counter widths are $clog2(max+1). No wrap: all counters saturate or stop at 0.
- Reset asserted mid-DRAIN or mid-bubble: immediate return to IDLE with zeroed counters.

Test Plan:
- Illegal in stage 1 (stage_valid=4'b0010, illegal=4'b0010) -> cycle 0: flush=4'b0111, trap_redirect=1, trap_stage=1; next 2 cycles: flush=4'b1111, trap_busy=1; cycle 3: IDLE, flush=0.
- Illegal in stages 1 and 3 simultaneously -> trap_stage=3, flush=4'b1111, a single trap_redirect pulse.
- Load-use with src_reg[0]=5, load_dest_reg=5, load_is_mem=1, LOAD_USE_BUBBLES=3 -> stall=4'b0011, flush=4'b0100 for exactly 3 cycles; with src_reg=0 and dest=0 -> no stall.
- Load-use plus stall_request held 2 cycles mid-bubble -> stall=4'b1111 and counter frozen during those cycles; bubble cycles still total 3.
- stall_request held with STALL_TIMEOUT=4 -> trap_redirect on the 5th stall cycle, trap_timeout=1, trap_stage=3; releasing stall_request earlier resets the watchdog.
- Branch in the same cycle as load-use detect -> flush=4'b0011, stall=0, bubble counter=0; reset pulse during DRAIN -> all outputs 0 and trap_busy=0 immediately.
